// File: rtl/spi_tx_arbiter_if.sv
// Requester/transmitter bundle for spi_tx_arbiter; master = arbiter side, slave = requesters + transmitter.
// No latency of its own; flow control is req held until done/fail, tx_start answered by tx_done/tx_error.
interface spi_tx_arbiter_if #(
  parameter int spi_count = 32,
  parameter int NUM_REQ   = 4
);
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*spi_count-1:0] req_data;
  logic                         tx_start;
  logic [spi_count-1:0]         tx_data;
  logic                         tx_done;
  logic                         tx_error;
  logic [NUM_REQ-1:0]           gnt;
  logic [NUM_REQ-1:0]           done;
  logic [NUM_REQ-1:0]           fail;
  logic                         busy;
  logic [1:0]                   state;

  modport master (
    input  req, req_data, tx_done, tx_error,
    output tx_start, tx_data, gnt, done, fail, busy, state
  );

  modport slave (
    output req, req_data, tx_done, tx_error,
    input  tx_start, tx_data, gnt, done, fail, busy, state
  );
endinterface

// File: rtl/spi_tx_arbiter.sv
// Round-robin arbiter feeding one SPI transmitter with bounded retry; SPI_ARB_TIMEOUT_EN adds a WAIT watchdog.
// tx_start 2 cycles after req in IDLE; requesters hold req until done/fail, one transfer in flight at a time.
module spi_tx_arbiter #(
  parameter int spi_count = 32,
  parameter int NUM_REQ   = 4,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 1024
) (
  input logic              clk_in,
  input logic              reset,
  spi_tx_arbiter_if.master bus
);
  localparam int IDXW = $clog2(NUM_REQ);
  localparam int RTYW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, WAIT = 2'd2, RETIRE = 2'd3} state_t;

  state_t               state_q, state_d;
  logic [IDXW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0]      gnt_idx_q, gnt_idx_d;
  logic [RTYW-1:0]      retry_q, retry_d;
  logic [spi_count-1:0] tx_data_q, tx_data_d;
  logic                 tx_start_q, tx_start_d;
  logic                 ok_q, ok_d;
  logic                 tx_done_q;
  logic                 pick_vld;
  logic [IDXW-1:0]      pick_idx, scan_idx;
  logic                 tx_done_rise, attempt_bad, busy;
  logic [NUM_REQ-1:0]   gnt_onehot;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wdog_q, wdog_d;
  logic           wdog_hit;

  assign wdog_hit = (state_q == WAIT) && (wdog_q == WDW'(TIMEOUT - 1));

  always_comb begin
    wdog_d = wdog_q;
    if (state_q == LOAD) begin
      wdog_d = '0;
    end else if ((state_q == WAIT) && !wdog_hit) begin
      wdog_d = wdog_q + WDW'(1);
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) wdog_q <= '0;
    else        wdog_q <= wdog_d;
  end

  // A watchdog expiry is just another failed attempt.
  assign attempt_bad = bus.tx_error || wdog_hit;
`else
  assign attempt_bad = bus.tx_error;
`endif

  assign tx_done_rise = bus.tx_done & ~tx_done_q;

  // Scan downward so the closest index at/after rr_ptr wins the last write.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = IDXW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (bus.req[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_idx_d  = gnt_idx_q;
    retry_d    = retry_q;
    tx_data_d  = tx_data_q;
    ok_d       = ok_q;
    tx_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_idx_d = pick_idx;
          tx_data_d = bus.req_data[int'(pick_idx)*spi_count +: spi_count];
          retry_d   = '0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        tx_start_d = 1'b1;
        state_d    = WAIT;
      end
      WAIT: begin
        // Error wins over a coincident completion edge.
        if (attempt_bad) begin
          if (retry_q < RTYW'(MAX_RETRY)) begin
            retry_d = retry_q + RTYW'(1);
            state_d = LOAD;
          end else begin
            ok_d    = 1'b0;
            state_d = RETIRE;
          end
        end else if (tx_done_rise) begin
          ok_d    = 1'b1;
          state_d = RETIRE;
        end
      end
      RETIRE: begin
        rr_ptr_d = (gnt_idx_q == IDXW'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IDXW'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      gnt_idx_q  <= '0;
      retry_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      ok_q       <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_idx_q  <= gnt_idx_d;
      retry_q    <= retry_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      ok_q       <= ok_d;
      tx_done_q  <= bus.tx_done;
    end
  end

  assign busy       = (state_q != IDLE);
  assign gnt_onehot = NUM_REQ'(1) << gnt_idx_q;

  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.busy     = busy;
  assign bus.state    = state_q;
  assign bus.gnt      = busy ? gnt_onehot : '0;
  assign bus.done     = ((state_q == RETIRE) && ok_q)  ? gnt_onehot : '0;
  assign bus.fail     = ((state_q == RETIRE) && !ok_q) ? gnt_onehot : '0;
endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Directed bench for spi_tx_arbiter: latency, round-robin order, retry/fail, level tx_done, watchdog, async reset.
module tb_spi_tx_arbiter;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int MR = 3;
  localparam int TO = 16;

  logic clk_in = 1'b0;
  logic reset  = 1'b0;
  int checks = 0;
  int passed = 0;
  int n_start = 0;
  int n_done  = 0;
  int n_fail  = 0;
  logic [N-1:0] last_done = '0;
  logic [N-1:0] last_fail = '0;
  logic [W-1:0] start_data [$];

  always #5 clk_in = ~clk_in;

  spi_tx_arbiter_if #(.spi_count(W), .NUM_REQ(N)) bus ();

  spi_tx_arbiter #(.spi_count(W), .NUM_REQ(N), .MAX_RETRY(MR), .TIMEOUT(TO)) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus)
  );

  always @(negedge clk_in) begin
    if (bus.tx_start === 1'b1) begin
      n_start++;
      start_data.push_back(bus.tx_data);
    end
    if (bus.done !== '0) begin
      n_done++;
      last_done = bus.done;
    end
    if (bus.fail !== '0) begin
      n_fail++;
      last_fail = bus.fail;
    end
  end

  task automatic clr_mon();
    n_start = 0;
    n_done  = 0;
    n_fail  = 0;
    start_data.delete();
  endtask

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk_in);
      if (bus.tx_start === 1'b1) seen = 1'b1;
    end
  endtask

  // Returns at the negedge of the RETIRE cycle.
  task automatic pulse_done(input int delay);
    repeat (delay) @(posedge clk_in);
    #1 bus.tx_done = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic pulse_err(input int delay);
    repeat (delay) @(posedge clk_in);
    #1 bus.tx_error = 1'b1;
    @(posedge clk_in);
    #1 bus.tx_error = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else passed++;
    checks++; if (bus.state !== 2'd0) $display("FAIL reset_state: got %0d want 0", bus.state); else passed++;
    checks++; if (bus.gnt !== 4'b0) $display("FAIL reset_gnt: got %b want 0000", bus.gnt); else passed++;
    checks++; if (bus.tx_start !== 1'b0) $display("FAIL reset_tx_start: got %b want 0", bus.tx_start); else passed++;
    checks++; if (bus.tx_data !== 32'h0) $display("FAIL reset_tx_data: got %h want 0", bus.tx_data); else passed++;
    checks++; if ((bus.done | bus.fail) !== 4'b0) $display("FAIL reset_done_fail: got %b/%b want 0", bus.done, bus.fail); else passed++;
    bus.req = 4'b1111;
    repeat (3) @(negedge clk_in);
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_hold_busy: got %b want 0", bus.busy); else passed++;
    bus.req = '0;
    #2 reset = 1'b1;
  endtask

  task automatic test_single();
    bit seen;
    @(posedge clk_in); #1;
    clr_mon();
    bus.req_data = '0;
    bus.req_data[W-1:0] = 32'h0000_00A5;
    bus.req = 4'b0001;
    @(negedge clk_in);
    checks++; if (bus.state !== 2'd0) $display("FAIL single_idle: got state %0d want 0", bus.state); else passed++;
    @(negedge clk_in);
    checks++; if (bus.state !== 2'd1) $display("FAIL single_load: got state %0d want 1", bus.state); else passed++;
    checks++; if (bus.gnt !== 4'b0001) $display("FAIL single_gnt: got %b want 0001", bus.gnt); else passed++;
    checks++; if (bus.tx_start !== 1'b0) $display("FAIL single_start_early: got %b want 0", bus.tx_start); else passed++;
    @(negedge clk_in);
    checks++; if (bus.tx_start !== 1'b1) $display("FAIL single_latency: tx_start got %b want 1", bus.tx_start); else passed++;
    checks++; if (bus.tx_data !== 32'h0000_00A5) $display("FAIL single_data: got %h want 000000a5", bus.tx_data); else passed++;
    pulse_done(39);
    checks++; if (bus.done !== 4'b0001) $display("FAIL single_done: got %b want 0001", bus.done); else passed++;
    checks++; if (bus.tx_data !== 32'h0000_00A5) $display("FAIL single_data_hold: got %h want 000000a5", bus.tx_data); else passed++;
    bus.req = '0;
    bus.tx_done = 1'b0;
    @(negedge clk_in);
    checks++; if (bus.busy !== 1'b0) $display("FAIL single_busy_after: got %b want 0", bus.busy); else passed++;
    checks++; if (n_start != 1 || n_done != 1) $display("FAIL single_counts: got starts %0d dones %0d want 1 1", n_start, n_done); else passed++;
    seen = 1'b0;
  endtask

  task automatic test_round_robin();
    bit seen;
    int exp_idx [5];
    logic [N-1:0] eg;
    exp_idx = '{0, 1, 2, 3, 0};
    @(posedge clk_in); #1;
    reset = 1'b0;
    #3 reset = 1'b1;
    for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = 32'hC0DE_0000 + 32'(i);
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      eg = 4'b0001 << exp_idx[g];
      wait_start(seen);
      checks++; if (!seen) $display("FAIL rr_start_%0d: no tx_start within 40 cycles", g); else passed++;
      checks++; if (bus.gnt !== eg) $display("FAIL rr_gnt_%0d: got %b want %b", g, bus.gnt, eg); else passed++;
      checks++; if (bus.tx_data !== 32'hC0DE_0000 + 32'(exp_idx[g])) $display("FAIL rr_data_%0d: got %h want %h", g, bus.tx_data, 32'hC0DE_0000 + 32'(exp_idx[g])); else passed++;
      pulse_done(2);
      checks++; if (bus.done !== eg) $display("FAIL rr_done_%0d: got %b want %b", g, bus.done, eg); else passed++;
      bus.tx_done = 1'b0;
      if (g == 4) bus.req = '0;
    end
    @(negedge clk_in);
    @(negedge clk_in);
    checks++; if (bus.busy !== 1'b0) $display("FAIL rr_idle: busy got %b want 0", bus.busy); else passed++;
  endtask

  task automatic test_retry();
    bit seen;
    int bad;
    @(posedge clk_in); #1;
    clr_mon();
    bus.req_data[2*W +: W] = 32'h5A5A_1234;
    bus.req = 4'b0100;
    wait_start(seen);
    checks++; if (!seen) $display("FAIL retry_start_1: no tx_start"); else passed++;
    pulse_err(3);
    wait_start(seen);
    checks++; if (!seen) $display("FAIL retry_start_2: no tx_start"); else passed++;
    // Coincident done edge and error must count as an error.
    repeat (3) @(posedge clk_in);
    #1 begin bus.tx_done = 1'b1; bus.tx_error = 1'b1; end
    @(posedge clk_in);
    #1 begin bus.tx_done = 1'b0; bus.tx_error = 1'b0; end
    wait_start(seen);
    checks++; if (!seen) $display("FAIL retry_start_3: no tx_start"); else passed++;
    pulse_done(2);
    checks++; if (bus.done !== 4'b0100) $display("FAIL retry_done: got %b want 0100", bus.done); else passed++;
    bus.tx_done = 1'b0;
    bus.req = '0;
    @(negedge clk_in);
    checks++; if (n_start != 3) $display("FAIL retry_starts: got %0d want 3", n_start); else passed++;
    checks++; if (n_done != 1 || n_fail != 0) $display("FAIL retry_pulses: got done %0d fail %0d want 1 0", n_done, n_fail); else passed++;
    bad = 0;
    foreach (start_data[i]) if (start_data[i] !== 32'h5A5A_1234) bad++;
    checks++; if (bad != 0) $display("FAIL retry_same_data: got %0d differing words want 0", bad); else passed++;
  endtask

  task automatic test_fail();
    bit seen;
    @(posedge clk_in); #1;
    clr_mon();
    bus.req_data[3*W +: W] = 32'hDEAD_BEEF;
    bus.req = 4'b1000;
    for (int a = 0; a < 4; a++) begin
      wait_start(seen);
      checks++; if (!seen) $display("FAIL fail_attempt_%0d: no tx_start", a); else passed++;
      pulse_err(2);
    end
    @(negedge clk_in);
    checks++; if (bus.fail !== 4'b1000) $display("FAIL fail_pulse: got %b want 1000", bus.fail); else passed++;
    bus.req = '0;
    @(negedge clk_in);
    checks++; if (n_start != 4 || n_fail != 1 || n_done != 0) $display("FAIL fail_counts: got starts %0d fails %0d dones %0d want 4 1 0", n_start, n_fail, n_done); else passed++;
    bus.req_data[W-1:0] = 32'h0000_0F0F;
    bus.req = 4'b1001;
    wait_start(seen);
    checks++; if (bus.gnt !== 4'b0001) $display("FAIL fail_rr_advance: got %b want 0001", bus.gnt); else passed++;
    pulse_done(2);
    checks++; if (bus.done !== 4'b0001) $display("FAIL fail_rr_done: got %b want 0001", bus.done); else passed++;
    bus.req = '0;
    bus.tx_done = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic test_done_level();
    bit seen;
    @(posedge clk_in); #1;
    clr_mon();
    bus.tx_done = 1'b1;
    bus.req = 4'b0010;
    wait_start(seen);
    checks++; if (!seen) $display("FAIL level_start: no tx_start"); else passed++;
    repeat (10) @(negedge clk_in);
    checks++; if (bus.state !== 2'd2 || n_done != 0) $display("FAIL level_ignored: got state %0d dones %0d want 2 0", bus.state, n_done); else passed++;
    @(posedge clk_in); #1 bus.tx_done = 1'b0;
    pulse_done(2);
    checks++; if (bus.done !== 4'b0010) $display("FAIL level_done: got %b want 0010", bus.done); else passed++;
    bus.req = '0;
    bus.tx_done = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic test_timeout();
    bit seen;
    @(posedge clk_in); #1;
    clr_mon();
    bus.req = 4'b0001;
    wait_start(seen);
    checks++; if (!seen) $display("FAIL to_start: no tx_start"); else passed++;
`ifdef SPI_ARB_TIMEOUT_EN
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk_in);
      if (bus.fail !== '0) seen = 1'b1;
    end
    checks++; if (bus.fail !== 4'b0001) $display("FAIL to_fail: got %b want 0001", bus.fail); else passed++;
    bus.req = '0;
    @(negedge clk_in);
    checks++; if (n_start != 4 || n_fail != 1) $display("FAIL to_counts: got starts %0d fails %0d want 4 1", n_start, n_fail); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL to_idle: busy got %b want 0", bus.busy); else passed++;
`else
    repeat (100) @(negedge clk_in);
    checks++; if (bus.busy !== 1'b1 || bus.state !== 2'd2) $display("FAIL to_persist: got busy %b state %0d want 1 2", bus.busy, bus.state); else passed++;
    checks++; if (n_start != 1 || n_fail != 0) $display("FAIL to_no_retry: got starts %0d fails %0d want 1 0", n_start, n_fail); else passed++;
    pulse_done(0);
    checks++; if (bus.done !== 4'b0001) $display("FAIL to_done: got %b want 0001", bus.done); else passed++;
    bus.req = '0;
    bus.tx_done = 1'b0;
    @(negedge clk_in);
`endif
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(posedge clk_in); #1;
    clr_mon();
    bus.req_data[2*W +: W] = 32'h7777_0002;
    bus.req = 4'b0100;
    wait_start(seen);
    repeat (3) @(negedge clk_in);
    checks++; if (bus.gnt !== 4'b0100 || bus.state !== 2'd2) $display("FAIL mid_pre: got gnt %b state %0d want 0100 2", bus.gnt, bus.state); else passed++;
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.gnt !== 4'b0 || bus.busy !== 1'b0 || bus.state !== 2'd0) $display("FAIL mid_async: got gnt %b busy %b state %0d want 0000 0 0", bus.gnt, bus.busy, bus.state); else passed++;
    checks++; if (bus.tx_data !== 32'h0 || bus.tx_start !== 1'b0) $display("FAIL mid_async_tx: got data %h start %b want 0 0", bus.tx_data, bus.tx_start); else passed++;
    bus.req_data[W-1:0] = 32'h1111_0000;
    bus.req = 4'b0101;
    repeat (3) @(negedge clk_in);
    checks++; if (n_done != 0 || n_fail != 0) $display("FAIL mid_no_pulse: got dones %0d fails %0d want 0 0", n_done, n_fail); else passed++;
    reset = 1'b1;
    wait_start(seen);
    checks++; if (bus.gnt !== 4'b0001) $display("FAIL mid_regrant: got %b want 0001", bus.gnt); else passed++;
    checks++; if (bus.tx_data !== 32'h1111_0000) $display("FAIL mid_data: got %h want 11110000", bus.tx_data); else passed++;
    pulse_done(2);
    checks++; if (bus.done !== 4'b0001) $display("FAIL mid_done: got %b want 0001", bus.done); else passed++;
    bus.req = '0;
    bus.tx_done = 1'b0;
    @(negedge clk_in);
  endtask

  initial begin
    bus.req      = '0;
    bus.req_data = '0;
    bus.tx_done  = 1'b0;
    bus.tx_error = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_retry();
    test_fail();
    test_done_level();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench still running at %0t", $time);
    $fatal(1);
  end
endmodule

// File: doc/spi_tx_arbiter.md
SPI_TX_ARBITER -- requirements
Module: spi_tx_arbiter

Interface
REQ-001 Parameter: spi_count, default 32, width of each SPI data word.
REQ-002 Parameter: NUM_REQ, default 4, number of requesters (2..8).
REQ-003 Parameter: MAX_RETRY, default 3, retries after first failed attempt.
REQ-004 Parameter: TIMEOUT, default 1024, clk_in cycles allowed in WAIT.
REQ-005 clk_in  input  1  sole clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 req  input  NUM_REQ  per-requester transfer request, level; held until done or fail pulse.
REQ-008 req_data  input  NUM_REQ*spi_count  word i at bits [i*spi_count +: spi_count].
REQ-009 tx_start  output  1  one-cycle pulse to the SPI transmitter.
REQ-010 tx_data  output  spi_count  word presented to the transmitter; stable from LOAD until return to IDLE.
REQ-011 tx_done  input  1  transmitter shift-complete level.
REQ-012 tx_error  input  1  transmitter/receiver error level.
REQ-013 gnt  output  NUM_REQ  one-hot grant, high from LOAD through RETIRE.
REQ-014 done  output  NUM_REQ  one-cycle success pulse to granted requester.
REQ-015 fail  output  NUM_REQ  one-cycle failure pulse to granted requester.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 state  output  2  debug: IDLE=0, LOAD=1, WAIT=2, RETIRE=3.

Function
REQ-018 IDLE: if any req bit high, grant the first set bit at or above rr_ptr (wrapping), latch its word into tx_data, clear retry count, go LOAD next cycle.
REQ-019 LOAD: assert tx_start for exactly one cycle, clear watchdog, go WAIT.
REQ-020 WAIT: tx_done rising edge (registered edge detect) with tx_error low -> RETIRE with success.
REQ-021 WAIT: tx_error high -> if retry count < MAX_RETRY increment it and go LOAD, else RETIRE with failure.
REQ-022 Simultaneous tx_done rising edge and tx_error high SHALL be treated as error.
REQ-023 RETIRE: pulse done or fail for the granted index, set rr_ptr to granted index+1 modulo NUM_REQ, go IDLE.
REQ-024 Request-to-tx_start latency SHALL be 2 cycles from IDLE.
REQ-025 Deasserting req of the granted requester mid-transfer SHALL NOT abort; done/fail still pulses.
REQ-026 A requester SHALL NOT be re-granted before every other continuously-requesting requester has been served once.
REQ-027 tx_done already high on entry to WAIT SHALL NOT count as completion; only a rising edge does.
REQ-028 Retry re-sends the latched word unchanged.

Reset
REQ-029 reset low SHALL asynchronously force state=IDLE, rr_ptr=0, retry count=0, watchdog=0, edge register=0, tx_data=0, and tx_start, gnt, done, fail, busy all 0.
REQ-030 reset low mid-transfer SHALL drop grant without a done or fail pulse; first arbitration after release starts from index 0.

Configuration
REQ-031 Macro SPI_ARB_TIMEOUT_EN defined: watchdog counts WAIT cycles; reaching TIMEOUT with no completion is handled exactly as tx_error (retry or fail).
REQ-032 SPI_ARB_TIMEOUT_EN undefined: no watchdog logic; WAIT persists until tx_done edge or tx_error.

Verification
REQ-033 req=4'b0001, data0=0x0000_00A5, tx_done rises 40 cycles after tx_start -> tx_start 2 cycles after req, tx_data=0x0000_00A5, done=4'b0001 pulse, busy low after RETIRE.
REQ-034 req=4'b1111 held, each transfer succeeds -> grant order 0,1,2,3,0; no index served twice in any four consecutive grants.
REQ-035 tx_error asserted on first two attempts, third succeeds -> three tx_start pulses, same tx_data, one done pulse, no fail.
REQ-036 tx_error on every attempt, MAX_RETRY=3 -> four tx_start pulses then fail pulse for granted index, rr_ptr advances.
REQ-037 With SPI_ARB_TIMEOUT_EN, TIMEOUT=16, tx_done never rises -> retry every 16 cycles in WAIT, fail after fourth attempt; without macro, busy stays high indefinitely.
REQ-038 reset pulled low during WAIT with gnt=4'b0100 -> all outputs 0 immediately, no done/fail; after release req=4'b0101 grants index 0 first.
